gfx_mem_arbiter: RTL and testbench
==================================

# gfx_mem_arbiter

Read arbiter between the graphics block's four memory clients (sprite controller, bg0, bg1, overlay/framebuffer) and the single synchronous video memory read port. Each cycle it grants at most one pending request in round-robin order and drives the address to memory. One cycle later it returns the memory word to that client with a one-cycle `rready` pulse. It sits directly upstream of the graphics block's `*_rvalid`/`*_rready` memory ports.

## Interface
- `AW`, 16: memory/client address width.
- `DW`, 16: memory/client data width.
- `CLK` in 1: system clock; all state on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `spcon_memory_address`, `bg0_memory_address`, `bg1_memory_address`, `ov_memory_address` in AW each: client read addresses, held stable while the matching rvalid is high.
- `spcon_rvalid`, `bg0_rvalid`, `bg1_rvalid`, `ov_rvalid` in 1 each: client read requests (level).
- `spcon_memory_data`, `bg0_memory_data`, `bg1_memory_data`, `ov_memory_data` out DW each: broadcast copy of `mem_data`.
- `spcon_rready`, `bg0_rready`, `bg1_rready`, `ov_rready` out 1 each: one-cycle pulse meaning client data is valid this cycle.
- `mem_stall` in 1: memory owned by another master this cycle; no grant is issued.
- `mem_address` out AW: read address to memory.
- `mem_rd` out 1: read strobe; memory returns data on `mem_data` in the next cycle.
- `mem_data` in DW: memory read data, valid the cycle after `mem_rd`.

## Operation
- Client indices are 0 = spcon, 1 = bg0, 2 = bg1, 3 = ov.
- Eligible set: `elig[i] = rvalid[i] & ~(ret_valid & ret_id == i)`. The client whose data returns this cycle cannot be re-granted in the same cycle, because its address is still the old one.
- Grant (combinational): if `mem_stall` is low and `elig` is non-zero, grant the first eligible index found searching upward from `rr_ptr`, modulo 4.
- On a grant to index g: `mem_rd = 1`, `mem_address = address[g]`.
- With no grant: `mem_rd = 0`, `mem_address = 0`.
- Registered state:
  - `rr_ptr` (2 bits): on a grant, loads `(g+1) mod 4`; otherwise holds.
  - `ret_valid` (1 bit): loads the grant flag each cycle.
  - `ret_id` (2 bits): loads g on a grant; otherwise holds.
- Return: `rready[i] = ret_valid & (ret_id == i)`, which is one-hot or zero.
- All four `*_memory_data` outputs equal `mem_data` continuously. They are not gated.
- Client contract: sample data in the `rready` cycle, then present the next address or drop rvalid in the following cycle. Dropping rvalid before `rready` does not cancel an already-issued read; its `rready` still pulses and the client ignores it.
- `mem_stall` blocks new grants only. A return already in flight completes normally.
- Width rules: `rr_ptr` wraps 3 -> 0; no other arithmetic.

## Timing
- Reset values: `rr_ptr = 0`, `ret_valid = 0`, `ret_id = 0`. Therefore all `rready = 0`, and `mem_rd = 0` while RST is high. `mem_address = 0` when nothing is granted.
- Reset asserted mid-transaction: the pending `rready` is lost (`ret_valid` is cleared asynchronously). Clients re-request after reset.
- Latency: an uncontended request with rvalid high in cycle t gives `mem_rd` in cycle t and `rready` in cycle t+1.
- Throughput: one grant per cycle across different clients. A single client gets at most one grant every 2 cycles.
- Worst-case wait with all four requesting: 3 cycles from request to grant, excluding stall cycles.
- Path from rvalid/address to `mem_rd`/`mem_address` is combinational. `rready` is registered.

## Test plan
- Single request: bg0 rvalid=1 with address 0x1234 in cycle 0 -> `mem_rd=1` and `mem_address=0x1234` in cycle 0; memory returns 0xBEEF in cycle 1 -> `bg0_rready=1` in cycle 1, `bg0_memory_data=0xBEEF`, other rready 0.
- All four request continuously from reset -> grant order spcon, bg0, bg1, ov, spcon, …, one per cycle; each client's rready pulses every 4 cycles; `rr_ptr` wraps 3 -> 0.
- Back-to-back single client: ov holds rvalid high and advances its address after each rready -> `mem_rd` every other cycle (cycles 0, 2, 4); ov never granted in its own rready cycle.
- Stall: spcon requests; `mem_stall=1` for cycles 0-2, low in cycle 3 -> first `mem_rd` in cycle 3, `spcon_rready` in cycle 4, `rr_ptr` unchanged through cycles 0-2. A stall in the cycle after a grant still lets `rready` pulse.
- Early drop: bg1 granted in cycle 0, rvalid deasserted in cycle 1 -> `bg1_rready` still 1 in cycle 1; no further grant to bg1.
- Reset mid-flight: RST pulsed asynchronously between a grant and its return -> `rready` stays 0, `rr_ptr` = 0, `mem_rd` = 0 during reset; after release, spcon has first priority.

Source files
------------

// File: rtl/gfx_mem_arbiter.sv
// Round-robin read arbiter that shares one synchronous video memory read port
// between the four graphics clients and returns each word one cycle later.
module gfx_mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] spcon_memory_address,
  input  logic [AW-1:0] bg0_memory_address,
  input  logic [AW-1:0] bg1_memory_address,
  input  logic [AW-1:0] ov_memory_address,
  input  logic          spcon_rvalid,
  input  logic          bg0_rvalid,
  input  logic          bg1_rvalid,
  input  logic          ov_rvalid,
  output logic [DW-1:0] spcon_memory_data,
  output logic [DW-1:0] bg0_memory_data,
  output logic [DW-1:0] bg1_memory_data,
  output logic [DW-1:0] ov_memory_data,
  output logic          spcon_rready,
  output logic          bg0_rready,
  output logic          bg1_rready,
  output logic          ov_rready,
  input  logic          mem_stall,
  output logic [AW-1:0] mem_address,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data
);

  logic [3:0]    rvalid;
  logic [AW-1:0] addr [4];
  logic [3:0]    elig;

  logic [1:0] rr_ptr_q,    rr_ptr_d;
  logic       ret_valid_q, ret_valid_d;
  logic [1:0] ret_id_q,    ret_id_d;

  logic       grant_vld;
  logic [1:0] grant_id;
  logic [1:0] idx;

  assign rvalid  = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
  assign addr[0] = spcon_memory_address;
  assign addr[1] = bg0_memory_address;
  assign addr[2] = bg1_memory_address;
  assign addr[3] = ov_memory_address;

  // The client being returned to still presents its old address, so skip it.
  always_comb begin
    elig = rvalid;
    if (ret_valid_q) begin
      elig[ret_id_q] = 1'b0;
    end
  end

  // Grant search upward from rr_ptr; no grants while stalled or held in reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_ptr_q;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_vld && elig[idx] && !mem_stall && !RST) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    ret_valid_d = grant_vld;
    ret_id_d    = ret_id_q;
    if (grant_vld) begin
      rr_ptr_d = grant_id + 2'd1;
      ret_id_d = grant_id;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q    <= '0;
      ret_valid_q <= 1'b0;
      ret_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ret_valid_q <= ret_valid_d;
      ret_id_q    <= ret_id_d;
    end
  end

  assign mem_rd      = grant_vld;
  assign mem_address = grant_vld ? addr[grant_id] : '0;

  assign spcon_rready = ret_valid_q && (ret_id_q == 2'd0);
  assign bg0_rready   = ret_valid_q && (ret_id_q == 2'd1);
  assign bg1_rready   = ret_valid_q && (ret_id_q == 2'd2);
  assign ov_rready    = ret_valid_q && (ret_id_q == 2'd3);

  // Read data is broadcast ungated; rready tells each client when to sample.
  assign spcon_memory_data = mem_data;
  assign bg0_memory_data   = mem_data;
  assign bg1_memory_data   = mem_data;
  assign ov_memory_data    = mem_data;

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed and randomized checks of gfx_mem_arbiter against a cycle-level
// behavioural model of the round-robin grant and one-cycle return.
module tb_gfx_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] addr [4];
  logic [3:0]  rv;
  logic        mem_stall;
  logic [15:0] mem_data;
  logic [15:0] dout [4];
  logic [3:0]  rr;
  logic [15:0] mem_address;
  logic        mem_rd;

  int m_ptr;
  int m_ret;
  int passed;
  int total;
  int grants;

  always #5 CLK = ~CLK;

  gfx_mem_arbiter #(.AW(16), .DW(16)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .spcon_memory_address (addr[0]),
    .bg0_memory_address   (addr[1]),
    .bg1_memory_address   (addr[2]),
    .ov_memory_address    (addr[3]),
    .spcon_rvalid         (rv[0]),
    .bg0_rvalid           (rv[1]),
    .bg1_rvalid           (rv[2]),
    .ov_rvalid            (rv[3]),
    .spcon_memory_data    (dout[0]),
    .bg0_memory_data      (dout[1]),
    .bg1_memory_data      (dout[2]),
    .ov_memory_data       (dout[3]),
    .spcon_rready         (rr[0]),
    .bg0_rready           (rr[1]),
    .bg1_rready           (rr[2]),
    .ov_rready            (rr[3]),
    .mem_stall            (mem_stall),
    .mem_address          (mem_address),
    .mem_rd               (mem_rd),
    .mem_data             (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic cycle(output int g);
    int c;
    logic [3:0]  exp_rr;
    logic [15:0] gaddr;
    @(negedge CLK);
    g = -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (g < 0 && !RST && !mem_stall && rv[c] && c != m_ret) g = c;
    end
    exp_rr = (m_ret >= 0) ? 4'(1 << m_ret) : 4'd0;
    gaddr  = (g >= 0) ? addr[g] : 16'd0;
    chk("mem_rd", 32'(mem_rd), (g >= 0) ? 32'd1 : 32'd0);
    chk("mem_address", 32'(mem_address), 32'(gaddr));
    chk("rready", 32'(rr), 32'(exp_rr));
    for (int i = 0; i < 4; i++) chk("memory_data", 32'(dout[i]), 32'(mem_data));
    if (g >= 0) grants++;
    @(posedge CLK);
    if (RST) begin
      m_ptr = 0;
      m_ret = -1;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % 4;
      m_ret = g;
    end else begin
      m_ret = -1;
    end
    #1;
    mem_data = (g >= 0) ? (gaddr ^ 16'h5A5A) : 16'($urandom);
  endtask

  initial begin
    int g;
    int seq [$];
    passed = 0; total = 0; grants = 0;
    m_ptr = 0; m_ret = -1;
    RST = 1'b1; rv = 4'hF; mem_stall = 1'b0; mem_data = 16'h0;
    for (int i = 0; i < 4; i++) addr[i] = 16'(16'h1000 * (i + 1));

    // Reset holds off grants even with all clients requesting.
    cycle(g);
    chk("reset_no_grant", 32'(g), 32'hFFFF_FFFF);
    RST = 1'b0; rv = 4'h0;
    cycle(g);

    // Single bg0 request returns 0xBEEF the following cycle.
    rv = 4'b0010; addr[1] = 16'h1234;
    cycle(g);
    chk("single_grant", 32'(g), 32'd1);
    rv = 4'b0000; mem_data = 16'hBEEF;
    cycle(g);
    chk("single_data", 32'(dout[1]), 32'hBEEF);

    // All four continuously: strict rotation one grant per cycle.
    RST = 1'b1; #1; RST = 1'b0; m_ptr = 0; m_ret = -1;
    rv = 4'hF;
    for (int n = 0; n < 8; n++) begin
      cycle(g);
      chk("rotation", 32'(g), 32'(n % 4));
    end
    rv = 4'h0;
    cycle(g);

    // Single client back-to-back: grants on every other cycle only.
    rv = 4'b1000; seq.delete();
    for (int n = 0; n < 6; n++) begin
      cycle(g);
      seq.push_back(g);
      if (rr[3]) addr[3] = addr[3] + 16'd1;
    end
    for (int n = 0; n < 6; n++) chk("ov_b2b", 32'(seq[n]), (n % 2 == 0) ? 32'd3 : 32'hFFFF_FFFF);
    rv = 4'h0;
    cycle(g);

    // Stall three cycles, then grant; a stall after a grant keeps the return.
    rv = 4'b0001; mem_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle(g);
      chk("stall_hold", 32'(g), 32'hFFFF_FFFF);
    end
    mem_stall = 1'b0;
    cycle(g);
    chk("stall_release", 32'(g), 32'd0);
    mem_stall = 1'b1; rv = 4'b0000;
    cycle(g);
    mem_stall = 1'b0;

    // Early drop: bg1 drops rvalid, return still pulses, no re-grant.
    rv = 4'b0100;
    cycle(g);
    rv = 4'b0000;
    cycle(g);
    chk("early_drop_regrant", 32'(g), 32'hFFFF_FFFF);
    cycle(g);

    // Reset between grant and return cancels the pending rready.
    rv = 4'b0110;
    cycle(g);
    #2 RST = 1'b1;
    #1;
    m_ptr = 0; m_ret = -1;
    chk("rst_rready", 32'(rr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    rv = 4'hF;
    cycle(g);
    RST = 1'b0;
    cycle(g);
    chk("post_reset_first", 32'(g), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rv = 4'($urandom);
      mem_stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) addr[i] = 16'($urandom);
      cycle(g);
    end
    chk("random_grants_seen", 32'(grants > 100), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
